// File: rtl/bank_sel_pkg.sv
// Shared types and helpers for the BRAM bank selector FSM.
// Holds the state encoding, error codes and the selector-byte validity check.
package bank_sel_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StClear,
    StHold,
    StError
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_SEL     = 2'b01;
  localparam err_code_t ERR_TIMEOUT = 2'b10;

  // A selector repeats the bank index in both nibbles (0x00, 0x11, 0x22, ...).
  function automatic logic sel_valid(input logic [7:0] sel_byte, input int unsigned num_banks);
    return (sel_byte[7:4] == sel_byte[3:0]) && (32'(sel_byte[3:0]) < num_banks);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// HOLD-state watchdog: counts enabled cycles and flags the last allowed one.
// LIMIT = 0 disables the watchdog entirely.
module hold_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (LIMIT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expires on the LIMIT-th enabled cycle since the last clear.
    assign expired = en && (cnt_q == Last);

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en && !expired) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/bank_select_fsm.sv
// Selects one of NUM_BANKS BRAM banks from a UART selector byte and holds the
// write window open until the host ends the session or the watchdog fires.
module bank_select_fsm
  import bank_sel_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned BANK_W        = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 flag_write,
  input  logic                 flag_end_write,
  output logic [BANK_W-1:0]    sel_bram,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 reset_bram,
  output logic                 flag_bram,
  output logic                 busy_sel_bram,
  output logic                 err_valid,
  output logic [1:0]           err_code
);

  state_e            state_q, state_d;
  logic [7:0]        sel_byte_q, sel_byte_d;
  logic [BANK_W-1:0] sel_bram_q, sel_bram_d;
  err_code_t         err_code_q, err_code_d;
  logic              expired;

  hold_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == StClear),
    .en      (state_q == StHold),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    sel_byte_d = sel_byte_q;
    sel_bram_d = sel_bram_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (flag_write && rx_ready) begin
          sel_byte_d = rx_data;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        if (sel_valid(sel_byte_q, NUM_BANKS)) begin
          sel_bram_d = sel_byte_q[BANK_W-1:0];
          state_d    = StClear;
        end else begin
          err_code_d = ERR_SEL;
          state_d    = StError;
        end
      end
      StClear: state_d = StHold;
      StHold: begin
        // End of session takes priority over a coincident timeout.
        if (flag_end_write) begin
          state_d = StIdle;
        end else if (expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = StError;
        end
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_byte_q <= '0;
      sel_bram_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sel_byte_q <= sel_byte_d;
      sel_bram_q <= sel_bram_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    bank_en = '0;
    if ((state_q == StClear) || (state_q == StHold)) begin
      bank_en = NUM_BANKS'(1) << sel_bram_q;
    end
  end

  assign sel_bram      = sel_bram_q;
  assign reset_bram    = (state_q == StClear);
  assign flag_bram     = (state_q == StClear) || (state_q == StHold);
  assign busy_sel_bram = (state_q != StIdle);
  assign err_valid     = (state_q == StError);
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_bank_select_fsm.sv
// Scoreboard bench for bank_select_fsm (NUM_BANKS=4, TIMEOUT_CYCLES=16):
// a cycle model queues expected outputs as inputs are driven.
module tb_bank_select_fsm;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       flag_write = 1'b0;
  logic       flag_end_write = 1'b0;
  logic [1:0] sel_bram;
  logic [3:0] bank_en;
  logic       reset_bram, flag_bram, busy_sel_bram, err_valid;
  logic [1:0] err_code;

  bank_select_fsm #(
    .NUM_BANKS      (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .flag_write     (flag_write),
    .flag_end_write (flag_end_write),
    .sel_bram       (sel_bram),
    .bank_en        (bank_en),
    .reset_bram     (reset_bram),
    .flag_bram      (flag_bram),
    .busy_sel_bram  (busy_sel_bram),
    .err_valid      (err_valid),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  logic [11:0] obs_vec;
  assign obs_vec = {sel_bram, bank_en, reset_bram, flag_bram, busy_sel_bram, err_valid, err_code};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [11:0] exp_q[$];

  // Model states: 0 idle, 1 decode, 2 clear, 3 hold, 4 error.
  int         m_state = 0;
  logic [7:0] m_byte = 8'h00;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_err = 2'd0;
  int         m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic rr, input logic [7:0] d,
                            input logic fw, input logic few);
    if (rst) begin
      m_state = 0; m_byte = 8'h00; m_sel = 2'd0; m_err = 2'd0; m_cnt = 0;
    end else begin
      case (m_state)
        0: if (fw && rr) begin m_byte = d; m_state = 1; end
        1: begin
          if ((m_byte[7:4] == m_byte[3:0]) && (m_byte[3:0] < 4'(NB))) begin
            m_sel = m_byte[1:0]; m_state = 2;
          end else begin
            m_err = 2'b01; m_state = 4;
          end
        end
        2: begin m_cnt = 0; m_state = 3; end
        3: begin
          if (few) m_state = 0;
          else if (m_cnt == int'(TO) - 1) begin m_err = 2'b10; m_state = 4; end
          else m_cnt++;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] be;
    be = 4'b0000;
    if (m_state == 2 || m_state == 3) be = 4'b0001 << m_sel;
    return {m_sel, be, (m_state == 2), (m_state == 2 || m_state == 3), (m_state != 0),
            (m_state == 4), m_err};
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic rr, input logic [7:0] d,
                     input logic fw, input logic few);
    logic [11:0] e;
    reset = rst; rx_ready = rr; rx_data = d; flag_write = fw; flag_end_write = few;
    model_step(rst, rr, d, fw, few);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, 32'(obs_vec), 32'(e));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_sel(input string tag, input logic [7:0] b);
    cyc(tag, 1'b0, 1'b1, b, 1'b1, 1'b0);
  endtask

  int holds;
  int errs;

  initial begin
    cyc("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("reset", 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    check_eq("reset_outputs_zero", 32'(obs_vec), 32'h0);

    // Strobe without armed session, and end-of-write in idle, are ignored.
    cyc("no_flag_write", 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc("end_in_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Bank 2 select, short session.
    send_sel("sel22", 8'h22);
    idle("sel22_decode", 1);
    check_eq("sel22_clear_pulse", 32'(reset_bram), 32'd1);
    idle("sel22_hold", 3);
    check_eq("sel22_bank_en", 32'(bank_en), 32'h4);
    cyc("sel22_end", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Bad selectors leave sel_bram at 2.
    send_sel("bad12", 8'h12);
    idle("bad12_flow", 2);
    check_eq("bad12_code", 32'(err_code), 32'h1);
    send_sel("bad55", 8'h55);
    idle("bad55_flow", 3);
    check_eq("bad55_sel_kept", 32'(sel_bram), 32'd2);

    // Timeout: exactly TO hold cycles then one error cycle.
    send_sel("to11", 8'h11);
    idle("to11_decode", 1);
    holds = 0; errs = 0;
    for (int i = 0; i < int'(TO) + 4; i++) begin
      cyc("to11_run", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (flag_bram && !reset_bram) holds++;
      if (err_valid) begin
        errs++;
        check_eq("to11_code", 32'(err_code), 32'h2);
      end
    end
    check_eq("to11_hold_cycles", 32'(holds), TO);
    check_eq("to11_err_pulses", 32'(errs), 32'd1);

    // End of write in the last hold cycle beats the timeout.
    send_sel("race11", 8'h11);
    idle("race11_pre", 2);
    idle("race11_hold", int'(TO) - 1);
    cyc("race11_end", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("race11_no_err", 32'(err_valid), 32'd0);
    idle("race11_after", 2);

    // Reset mid-hold on bank 3, then bank 0 accepted.
    send_sel("sel33", 8'h33);
    idle("sel33_hold", 4);
    cyc("sel33_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("sel33_reset_zero", 32'(obs_vec), 32'h0);
    send_sel("sel00", 8'h00);
    idle("sel00_hold", 4);
    check_eq("sel00_bank_en", 32'(bank_en), 32'h1);

    // Selector strobes during hold are ignored.
    for (int i = 0; i < 3; i++) begin
      cyc("hold_rx11", 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
      idle("hold_rx11_gap", 1);
    end
    check_eq("hold_rx11_sel", 32'(sel_bram), 32'd0);
    cyc("hold_rx11_end", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle("final", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bank_select_fsm.md
BANK_SELECT_FSM -- requirements
Module: bank_select_fsm

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 4, number of selectable BRAM banks (legal 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, the HOLD watchdog limit in clk cycles (0 = watchdog disabled).
REQ-003 The block SHALL have derived localparam BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-005 Ports, one per line (name  direction  width  meaning):
 clk  in  1  system clock, rising edge
 reset  in  1  synchronous, active-high reset
 rx_ready  in  1  UART byte strobe, one cycle
 rx_data  in  8  UART byte, valid with rx_ready
 flag_write  in  1  host write session armed
 flag_end_write  in  1  write session complete
 sel_bram  out  BANK_W  selected bank index
 bank_en  out  NUM_BANKS  one-hot enable of selected bank
 reset_bram  out  1  bank address/counter clear pulse
 flag_bram  out  1  bank write window open
 busy_sel_bram  out  1  FSM not in IDLE
 err_valid  out  1  one-cycle error strobe
 err_code  out  2  01 = bad selector, 10 = timeout, 00 = none

Function
REQ-006 The FSM SHALL have states IDLE, DECODE, CLEAR, HOLD, ERROR.
REQ-007 In IDLE, when flag_write && rx_ready, the FSM SHALL capture rx_data into sel_byte and go to DECODE next cycle; otherwise it SHALL stay in IDLE.
REQ-008 A selector byte SHALL be valid iff sel_byte[7:4] == sel_byte[3:0] and sel_byte[3:0] < NUM_BANKS (0x00 = bank 0, 0x11 = bank 1, 0x22 = bank 2, ...).
REQ-009 DECODE SHALL last one cycle: a valid byte goes to CLEAR and registers bank index sel_byte[BANK_W-1:0]; an invalid byte goes to ERROR with err_code 01.
REQ-010 CLEAR SHALL last one cycle with reset_bram=1 and flag_bram=1, then go to HOLD; it SHALL clear the watchdog counter.
REQ-011 HOLD SHALL assert flag_bram=1 and reset_bram=0, and SHALL return to IDLE on flag_end_write.
REQ-012 In HOLD with TIMEOUT_CYCLES>0, the watchdog SHALL count each HOLD cycle; if the count reaches TIMEOUT_CYCLES-1 without flag_end_write, the FSM SHALL go to ERROR with err_code 10.
REQ-013 If flag_end_write and the timeout occur in the same cycle, flag_end_write SHALL win (go to IDLE, no error).
REQ-014 ERROR SHALL last one cycle, then go to IDLE; err_valid SHALL be 1 exactly in the ERROR cycle, and err_code SHALL hold its value until the next error or reset.
REQ-015 bank_en SHALL be one-hot at bit sel_bram in CLEAR and HOLD, and all-zero in every other state.
REQ-016 sel_bram SHALL hold the last successfully decoded bank in all states (a bad selector leaves it unchanged).
REQ-017 busy_sel_bram SHALL be 1 in every state except IDLE.
REQ-018 rx_ready, rx_data and flag_write SHALL be ignored outside IDLE; flag_end_write SHALL be ignored outside HOLD.
REQ-019 All outputs SHALL be functions of registered state only (no combinational input-to-output path).

Reset
REQ-020 Reset SHALL force state IDLE, sel_byte 0, sel_bram 0, watchdog 0 and err_code 00, overriding any state, including mid-HOLD.
REQ-021 In the cycle after reset, every output SHALL be 0.

Structure
REQ-022 Package bank_sel_pkg SHALL hold the state enum, the err_code typedef/constants (ERR_NONE, ERR_SEL, ERR_TIMEOUT) and the selector-validity function.
REQ-023 The watchdog SHALL be a sub-module hold_timer (parameter LIMIT; ports clr, en, expired).

Verification
REQ-024 NUM_BANKS=4: flag_write=1, rx_ready pulse with 0x22 -> DECODE, then CLEAR (reset_bram=1 for one cycle), then HOLD with sel_bram=2, bank_en=0100 and flag_bram=1.
REQ-025 Selector byte 0x12, then 0x55 with NUM_BANKS=4 -> each gives ERROR, err_valid for one cycle, err_code=01, sel_bram unchanged, bank_en=0 throughout.
REQ-026 TIMEOUT_CYCLES=16, selector 0x11, no flag_end_write -> exactly 16 HOLD cycles, then ERROR with err_code=10, then IDLE.
REQ-027 TIMEOUT_CYCLES=16, flag_end_write in the 16th HOLD cycle -> IDLE, err_valid stays 0.
REQ-028 reset asserted in HOLD on bank 3 -> next cycle IDLE with all outputs 0; a new selector 0x00 is then accepted normally.
REQ-029 rx_ready pulses with 0x11 during HOLD on bank 0 -> ignored; sel_bram stays 0 until flag_end_write.
